// File: rtl/request_arbiter.sv
// Serialises NUM_REQ requesters onto one RAM port; fixed or round-robin pick, busy timeout with error.
// Latency 2 cycles from request to ready plus 1 per busy cycle; losers simply wait with req held.
module request_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            wen,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] be,
  output logic [NUM_REQ-1:0]            ready,
  output logic [DATA_W-1:0]             rdata,
  output logic                          err,
  output logic [2:0]                    grant_id,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [DATA_W/8-1:0]           ram_be,
  output logic                          ram_wen,
  output logic                          ram_ren,
  input  logic [DATA_W-1:0]             ram_rdata,
  input  logic                          ram_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   gnt_inc;
  logic               win_vld;
  logic               lat_wen;
  logic [CNT_W-1:0]   to_cnt;
  logic               to_expired;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               sel_wen;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [BE_W-1:0]    sel_be;
  int                 base;
  int                 slot;

  // Scan slots starting at the priority base; fixed mode always starts at 0.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    base    = (RR_MODE != 0) ? int'(rr_ptr) : 0;
    slot    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = (base + k >= NUM_REQ) ? base + k - NUM_REQ : base + k;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_vld && req[i] && i == slot) begin
          win_vld = 1'b1;
          win     = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win) begin
        sel_wen   = wen[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_be    = be[i*BE_W +: BE_W];
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_onehot[i] = (IDX_W'(i) == gnt);
    end
  end

  assign gnt_inc    = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign to_expired = (TIMEOUT != 0) && (to_cnt == CNT_W'(TIMEOUT));
  assign grant_id   = 3'(gnt);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      lat_wen   <= 1'b0;
      to_cnt    <= '0;
      ready     <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
      ram_wen   <= 1'b0;
      ram_ren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= '0;
          err   <= 1'b0;
          if (win_vld) begin
            gnt       <= win;
            lat_wen   <= sel_wen;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_be    <= sel_be;
            ram_wen   <= sel_wen;
            ram_ren   <= !sel_wen;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!ram_busy) begin
            rdata   <= lat_wen ? '0 : ram_rdata;
            err     <= 1'b0;
            ready   <= gnt_onehot;
            ram_wen <= 1'b0;
            ram_ren <= 1'b0;
            state   <= RESP;
          end else if (to_expired) begin
            rdata   <= '0;
            err     <= 1'b1;
            ready   <= gnt_onehot;
            ram_wen <= 1'b0;
            ram_ren <= 1'b0;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          ready  <= '0;
          err    <= 1'b0;
          to_cnt <= '0;
          if (RR_MODE != 0) rr_ptr <= gnt_inc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/request_arbiter.md
# request_arbiter

Parametrised memory request arbiter, successor to the single-port instruction/data request unit. Accepts up to NUM_REQ independent requesters (instruction fetch, data load/store, future DMA/debug) and serialises them onto one shared RAM port with a busy handshake. Adds:
- selectable fixed or round-robin arbitration;
- byte enables;
- a per-access busy timeout with an error response.

Sits between the core's fetch/load-store logic and the RAM.

## Interface
Parameters:
- NUM_REQ, 2, number of requester channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 255, busy-wait limit in cycles; 0 disables the timeout

Ports:
- clk  in  1  single clock; all state on its rising edge
- nRST  in  1  reset, asynchronous and active-low
- req  in  NUM_REQ  per-channel request; held high until that channel's ready
- wen  in  NUM_REQ  per-channel write (1) / read (0)
- addr  in  NUM_REQ*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  per-channel write data
- be  in  NUM_REQ*(DATA_W/8)  per-channel byte enables
- ready  out  NUM_REQ  one-cycle completion pulse to the granted channel
- rdata  out  DATA_W  read data; valid only while a ready bit is high
- err  out  1  high with ready when the access timed out
- grant_id  out  3  index of the channel currently being served
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_be  out  DATA_W/8  RAM byte enables
- ram_wen  out  1  RAM write strobe
- ram_ren  out  1  RAM read strobe
- ram_rdata  in  DATA_W  RAM read data
- ram_busy  in  1  RAM not done; an access completes on the first ACCESS cycle with ram_busy low

## Operation
States are IDLE, ACCESS and RESP.

- **IDLE**
  - ram_wen and ram_ren are low.
  - If any req bit is high, select the winner:
    - fixed mode: lowest set index;
    - RR mode: first set index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner's index, wen, addr, wdata and be into internal registers, then go to ACCESS.
- **ACCESS**
  - RAM outputs come from the latched registers. ram_wen = latched wen; ram_ren = !latched wen.
  - ram_busy low at the clock edge:
    - capture ram_rdata (write accesses capture 0);
    - err_next = 0;
    - go to RESP.
  - ram_busy high: increment the timeout counter.
    - If TIMEOUT≠0 and the counter reaches TIMEOUT, go to RESP with err_next = 1 and rdata = 0.
    - ram_wen and ram_ren drop on entry to RESP.
- **RESP**
  - ready[grant] = 1 and err = err_next for exactly one cycle; rdata holds the captured value.
  - RR mode: rr_ptr ← (grant+1) mod NUM_REQ.
  - Clear the timeout counter and return to IDLE.
- **Request handling rules**
  - Requests are latched at grant. Changes to req, addr or wdata after grant do not affect the access in flight.
  - A requester dropping req mid-access does not abort the access; ready still pulses.
  - Requests that lose arbitration wait; no request is lost and none is reported.

**Reset (nRST low, any state):**
- state = IDLE, rr_ptr = 0, timeout counter = 0, grant_id = 0.
- ready, err, rdata, ram_* outputs and latched registers are all 0.
- An in-flight access is abandoned with no response.

## Timing
- All outputs are registered, so there is no combinational path from any input to any output.
- Minimum latency: req high at edge 0 → ACCESS after edge 0 → with ram_busy low, RESP after edge 1 → ready high in the cycle after edge 1. This is 2 cycles, and each extra busy cycle adds 1.
- Maximum throughput is 1 access per 3 cycles (IDLE bubble after each RESP).
- Timeout: with busy held high, ready and err pulse TIMEOUT+1 cycles after entering ACCESS.
- Simultaneous requests resolve in one cycle. In RR mode, the arbitration in the IDLE after a RESP already sees the updated rr_ptr.
- With NUM_REQ=1, the block behaves as a pass-through with the same latency.

## Test plan
- **Reset:** nRST low mid-ACCESS with busy high → next cycle all outputs 0, state IDLE. After release, req[0] with addr 0x10 → ram_addr=0x10 and ram_ren=1 one cycle later.
- **Single read:** req[1], addr 0x40, busy low, ram_rdata 0xDEADBEEF → ready=2'b10 two cycles after req with rdata=0xDEADBEEF and err=0; ram_ren high for exactly 1 cycle.
- **Byte write under busy:** req[0], wen=1, addr 0x8, wdata 0x11223344, be=4'b0011, busy high 3 cycles → ram_wen held 4 cycles with ram_be=4'b0011; ready[0] pulses once, 5 cycles after req.
- **Fixed priority:** RR_MODE=0, req=2'b11 held continuously → channel 0 served every time; channel 1 is never granted while req[0] stays high.
- **Round-robin:** RR_MODE=1, NUM_REQ=4, req=4'b1111 held → grant_id sequence 0,1,2,3,0. Then req=4'b1001 after grant 0 → next grant is 3.
- **Timeout:** TIMEOUT=4, busy stuck high → ready and err pulse together after 5 ACCESS cycles with rdata=0. The next request proceeds normally once busy goes low.
